lb_event_irq_ctrl: RTL
======================

// Module: lb_event_irq_ctrl
// PURPOSE
//  Interrupt scheduler for the PicoBlaze core. Turns N_CH asynchronous event lines into
//  single-cycle rising-edge pulses and latches each pulse as a pending request.
//  Shares the core's single interrupt input between the channels using round-robin order.
//  Presents one winner at a time as {interrupt, event_id} and handshakes on interrupt_ack.
// PARAMETERS
//  N_CH   8   number of event channels (2..16)
//  ID_W   3   width of event_id; must equal clog2(N_CH)
// PORTS
//  clk            in   1      system clock; single clock domain
//  reset          in   1      synchronous, active-high reset
//  event_in       in   N_CH   raw event lines, asynchronous, level
//  enable_mask    in   N_CH   1 = channel eligible for grant
//  interrupt_ack  in   1      one-cycle ack pulse from PicoBlaze
//  clear_ovf      in   1      one-cycle pulse that clears all overflow bits
//  interrupt      out  1      to PicoBlaze interrupt input
//  event_id       out  ID_W   channel currently/last granted
//  pending        out  N_CH   latched, not-yet-granted events
//  overflow       out  N_CH   sticky: edge lost because pending was already set
// BEHAVIOUR
//  Reset values (sync, active-high):
//   - interrupt=0, event_id=0, pending=0, overflow=0, sync flops=0.
//   - last_grant=N_CH-1, so the first search starts at channel 0.
//  Edge capture, per channel:
//   - Pipeline: s0<=event_in, s1<=s0, s2<=s1; rise = s1 & ~s2.
//   - event_in high at edge k gives rise=1 during cycle k+1 and pending=1 after edge k+2.
//   - A level held high produces exactly one rise.
//   - pending is set on rise regardless of enable_mask. Masked channels stay pending, are
//     never granted, and become eligible when unmasked.
//   - rise while pending[i]=1 and no grant of i that cycle: overflow[i]<=1; pending unchanged.
//   - rise in the same cycle as the grant of i: pending[i] stays 1 (new event); no overflow.
//   - clear_ovf coincident with a new overflow event: set wins.
//  FSM states IDLE, ACTIVE, GAP:
//   - IDLE: if (pending & enable_mask) != 0, pick the first eligible channel searching
//     last_grant+1, +2, ... modulo N_CH. On the next edge: event_id<=winner,
//     last_grant<=winner, pending[winner]<=0, interrupt<=1, go to ACTIVE.
//     Latency from pending visible to interrupt high is 1 cycle.
//   - ACTIVE: interrupt held at 1 until interrupt_ack=1. On that edge interrupt<=0, go to GAP.
//     Changes to mask or pending do not alter event_id while in ACTIVE.
//   - GAP: one cycle with interrupt=0, always followed by IDLE. Guarantees a low interval
//     between back-to-back interrupts.
//   - interrupt_ack in IDLE or GAP is ignored.
//  event_id holds its value until the next grant; it stays valid for reading after ack.
//  reset asserted mid-operation (any state): all state cleared on that edge; interrupt=0
//   the following cycle. Edges in the sync pipeline are discarded.
//  All channels eligible at once: grants are strictly rotating; no channel starves.
// STRUCTURE
//  Include file lb_irq_defs.vh: FSM state encodings (IDLE=2'd0, ACTIVE=2'd1, GAP=2'd2).
//  Sub-module lb_edge_sync: 3-flop sync/edge detector with ports clk, reset, d, rise.
//   Instantiated N_CH times through generate.
//  Top level holds the pending/overflow registers, the round-robin search and the FSM.
// TESTING
//  1. Pulse event_in[3] high for 5 cycles, mask=8'hFF -> pending[3] 2 edges after
//     sampling, interrupt=1 one cycle later, event_id=3; ack -> interrupt=0, one GAP cycle.
//  2. Raise event_in[0],[2],[5] together, mask=FF, ack each -> event_id sequence 0,2,5.
//     Repeat with last_grant=2 -> order 5,0,2.
//  3. mask=8'hFE, raise event_in[0] -> pending[0]=1, interrupt stays 0.
//     Set mask=FF -> interrupt with event_id=0.
//  4. Two rises on ch1 before its grant -> overflow[1]=1, one interrupt only.
//     clear_ovf -> overflow=0. Rise on grant cycle -> second interrupt, overflow=0.
//  5. Assert reset during ACTIVE -> interrupt=0, pending=0, overflow=0 next cycle;
//     the next grant searches from channel 0.
//  6. Hold interrupt_ack high in IDLE with no events -> no state change; held
//     event_in level -> exactly one interrupt.

Source files
------------

// File: rtl/lb_event_irq_ctrl_pkg.sv
// Shared definitions for the PicoBlaze event interrupt scheduler:
// default sizing and the scheduler FSM state encoding.
package lb_event_irq_ctrl_pkg;

    localparam int DEF_N_CH = 8;
    localparam int DEF_ID_W = 3;

    // Scheduler states: IDLE searches, ACTIVE holds interrupt, GAP forces a low cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } irq_state_e;

endpackage

// File: rtl/lb_event_irq_ctrl_edge_sync.sv
// Three-flop synchroniser with rising-edge detect for one asynchronous event line.
// s0/s1 resolve metastability; s2 remembers the previous synchronised level so a
// held level yields exactly one rise pulse.
module lb_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    // sync_q[0] = s0, sync_q[1] = s1, sync_q[2] = s2
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Next value of the shift chain: new sample enters at s0.
    always_comb begin
        sync_d = {sync_q[1:0], d};
    end

    // Synchroniser shift register; reset discards any edge in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/lb_event_irq_ctrl.sv
// Interrupt scheduler for PicoBlaze: captures rising edges on N_CH event lines as
// pending requests, then shares the single interrupt input between the channels
// in round-robin order with an interrupt/ack handshake and a forced low GAP cycle.
module lb_event_irq_ctrl
    import lb_event_irq_ctrl_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int ID_W = DEF_ID_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] event_in,
    input  logic [N_CH-1:0] enable_mask,
    input  logic            interrupt_ack,
    input  logic            clear_ovf,
    output logic            interrupt,
    output logic [ID_W-1:0] event_id,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overflow
);

    logic [N_CH-1:0] rise_s;
    logic [N_CH-1:0] eligible_s;
    logic [N_CH-1:0] grant_vec_s;
    logic [N_CH-1:0] ovf_set_s;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overflow_q, overflow_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] event_id_q, event_id_d;
    logic [ID_W-1:0] winner_s;
    logic [ID_W-1:0] cand_s;
    logic            found_s;
    logic            interrupt_q, interrupt_d;
    int              rr_idx_s;
    irq_state_e      state_q, state_d;

    // One synchroniser/edge detector per event channel.
    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        lb_edge_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (event_in[g]),
            .rise  (rise_s[g])
        );
    end

    assign eligible_s = pending_q & enable_mask;

    // Round-robin search: first eligible channel after last_grant, wrapping modulo N_CH.
    always_comb begin
        winner_s = {ID_W{1'b0}};
        found_s  = 1'b0;
        rr_idx_s = 0;
        cand_s   = {ID_W{1'b0}};
        for (int off = 1; off <= N_CH; off++) begin
            rr_idx_s = (int'(last_grant_q) + off) % N_CH;
            cand_s   = ID_W'(rr_idx_s);
            if (!found_s && eligible_s[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Scheduler FSM next state, grant decision and registered-output next values.
    always_comb begin
        state_d      = state_q;
        interrupt_d  = interrupt_q;
        event_id_d   = event_id_q;
        last_grant_d = last_grant_q;
        grant_vec_s  = {N_CH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_vec_s  = {{(N_CH-1){1'b0}}, 1'b1} << winner_s;
                    event_id_d   = winner_s;
                    last_grant_d = winner_s;
                    interrupt_d  = 1'b1;
                    state_d      = ST_ACTIVE;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // event_id is frozen here; only the ack moves us on.
                if (interrupt_ack) begin
                    interrupt_d = 1'b0;
                    state_d     = ST_GAP;
                end else begin
                    interrupt_d = 1'b1;
                end
            end
            ST_GAP: begin
                interrupt_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                interrupt_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Pending/overflow update: a rise on the grant cycle re-arms pending instead of overflowing;
    // a new overflow beats a coincident clear.
    always_comb begin
        ovf_set_s = rise_s & pending_q & ~grant_vec_s;
        pending_d = (pending_q & ~grant_vec_s) | rise_s;
        if (clear_ovf) begin
            overflow_d = ovf_set_s;
        end else begin
            overflow_d = overflow_q | ovf_set_s;
        end
    end

    // State and output registers with synchronous reset; search restarts at channel 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            interrupt_q  <= 1'b0;
            event_id_q   <= {ID_W{1'b0}};
            last_grant_q <= ID_W'(N_CH - 1);
            pending_q    <= {N_CH{1'b0}};
            overflow_q   <= {N_CH{1'b0}};
        end else begin
            state_q      <= state_d;
            interrupt_q  <= interrupt_d;
            event_id_q   <= event_id_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    assign interrupt = interrupt_q;
    assign event_id  = event_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
